ahb_spi_ctrl: RTL and testbench

AHB-Lite slave front end for the `SPIMaster` core. It sits between the system bus and the SPI master. It buffers CPU-written transmit words in a small FIFO and sequences one SPI frame per FIFO entry by driving the master's enable, data and byte-count inputs. It captures the received word and byte count, and exposes status and an interrupt to software.

---
 rtl/spi_pkg.sv | 35 +++
 rtl/spi_tx_fifo.sv | 53 +++++
 rtl/ahb_spi_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ahb_spi_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the AHB-to-SPI-master front end: register map,
// status/control bit positions, FSM encoding and byte-count normalisation.
package spi_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  localparam int STAT_BUSY         = 0;
  localparam int STAT_TX_FULL      = 1;
  localparam int STAT_TX_EMPTY     = 2;
  localparam int STAT_RX_VALID     = 3;
  localparam int STAT_RX_OVF       = 4;
  localparam int STAT_TX_OVF       = 5;
  localparam int STAT_RX_BYTES_LSB = 8;
  localparam int STAT_TX_LEVEL_LSB = 12;

  localparam int CTRL_BYTES_LSB = 0;
  localparam int CTRL_IRQ_EN    = 8;

  localparam logic [2:0] BYTES_MAX = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } spi_state_t;

  // Byte counts outside 1..BYTES_MAX collapse to a full word.
  function automatic logic [2:0] norm_bytes(input logic [2:0] b);
    return (b == 3'd0 || b > BYTES_MAX) ? BYTES_MAX : b;
  endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Transmit FIFO: pointers wrap naturally, full/empty come from a separate
// occupancy count so the level can report 0..DEPTH.
module spi_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 35
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the registered count, so a push that lands together
  // with a pop while full is still rejected.
  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + LW'(do_push) - LW'(do_pop);
    end
  end

endmodule

// File: rtl/ahb_spi_ctrl.sv
// AHB-Lite slave that queues transmit words and sequences one SPIMaster
// frame per queued word, capturing the received word for software.
module ahb_spi_ctrl
  import spi_pkg::*;
#(
  parameter int TX_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsel_i,
  input  logic [3:0]  haddr_i,
  input  logic [1:0]  htrans_i,
  input  logic        hwrite_i,
  input  logic        hready_i,
  input  logic [31:0] hwdata_i,
  output logic [31:0] hrdata_o,
  output logic        hreadyout_o,
  output logic        hresp_o,
  output logic        spi_enable_o,
  output logic [31:0] spi_write_data_o,
  output logic [2:0]  spi_write_data_bytes_valid_o,
  input  logic [31:0] spi_read_data_i,
  input  logic [2:0]  spi_read_data_bytes_valid_i,
  input  logic        spi_done_i,
  output logic        irq_o
);

  localparam int LW = $clog2(TX_DEPTH) + 1;

  // Bus handshake: a transfer is accepted when hsel & hready & htrans[1] in
  // the address phase; the slave never stalls (hreadyout=1) and never errors,
  // so the data phase is always the very next cycle.
  logic       ap_valid;
  logic       dp_valid;
  logic       dp_write;
  logic [1:0] dp_reg;

  logic       wr_txdata, wr_ctrl, wr_status, rd_rxdata;
  logic [2:0] ctrl_bytes;
  logic       irq_en;
  logic       rx_valid, rx_ovf, tx_ovf;
  logic [31:0] rx_data;
  logic [2:0] rx_bytes;
  logic       capture;
  logic       busy;

  spi_state_t state;

  logic          fifo_pop, fifo_full, fifo_empty;
  logic [34:0]   fifo_rdata;
  logic [LW-1:0] fifo_level;
  logic [2:0]    tx_level;

  logic unused_bits;
  assign unused_bits = ^{haddr_i[1:0], htrans_i[0]};

  assign hreadyout_o = 1'b1;
  assign hresp_o     = 1'b0;

  assign ap_valid  = hsel_i & hready_i & htrans_i[1];
  assign wr_txdata = dp_valid & dp_write  & (dp_reg == REG_TXDATA);
  assign wr_ctrl   = dp_valid & dp_write  & (dp_reg == REG_CTRL);
  assign wr_status = dp_valid & dp_write  & (dp_reg == REG_STATUS);
  assign rd_rxdata = dp_valid & ~dp_write & (dp_reg == REG_RXDATA);
  assign capture   = (state == ACTIVE) & spi_done_i;
  assign fifo_pop  = (state == IDLE) & ~fifo_empty;
  assign busy      = (state != IDLE) | ~fifo_empty;
  assign tx_level  = 3'(fifo_level);

  spi_tx_fifo #(.DEPTH(TX_DEPTH), .WIDTH(35)) u_tx_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (wr_txdata),
    .wdata ({ctrl_bytes, hwdata_i}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    hrdata_o = '0;
    if (dp_valid & ~dp_write) begin
      case (dp_reg)
        REG_CTRL: begin
          hrdata_o[CTRL_BYTES_LSB +: 3] = ctrl_bytes;
          hrdata_o[CTRL_IRQ_EN]         = irq_en;
        end
        REG_STATUS: begin
          hrdata_o[STAT_BUSY]              = busy;
          hrdata_o[STAT_TX_FULL]           = fifo_full;
          hrdata_o[STAT_TX_EMPTY]          = fifo_empty;
          hrdata_o[STAT_RX_VALID]          = rx_valid;
          hrdata_o[STAT_RX_OVF]            = rx_ovf;
          hrdata_o[STAT_TX_OVF]            = tx_ovf;
          hrdata_o[STAT_RX_BYTES_LSB +: 3] = rx_bytes;
          hrdata_o[STAT_TX_LEVEL_LSB +: 3] = tx_level;
        end
        REG_RXDATA: hrdata_o = rx_data;
        default:    hrdata_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dp_valid   <= 1'b0;
      dp_write   <= 1'b0;
      dp_reg     <= '0;
      ctrl_bytes <= BYTES_MAX;
      irq_en     <= 1'b0;
      tx_ovf     <= 1'b0;
      rx_valid   <= 1'b0;
      rx_ovf     <= 1'b0;
      rx_data    <= '0;
      rx_bytes   <= '0;
      irq_o      <= 1'b0;
    end else begin
      dp_valid <= ap_valid;
      dp_write <= hwrite_i;
      dp_reg   <= haddr_i[3:2];

      if (wr_ctrl) begin
        ctrl_bytes <= norm_bytes(hwdata_i[CTRL_BYTES_LSB +: 3]);
        irq_en     <= hwdata_i[CTRL_IRQ_EN];
      end

      if (wr_txdata & fifo_full)                   tx_ovf <= 1'b1;
      else if (wr_status & hwdata_i[STAT_TX_OVF])  tx_ovf <= 1'b0;

      // A capture beats a same-cycle RXDATA read: the reader got the old word.
      if (capture) begin
        rx_data  <= spi_read_data_i;
        rx_bytes <= spi_read_data_bytes_valid_i;
        rx_valid <= 1'b1;
      end else if (rd_rxdata) begin
        rx_valid <= 1'b0;
      end

      if (capture & rx_valid)                      rx_ovf <= 1'b1;
      else if (wr_status & hwdata_i[STAT_RX_OVF])  rx_ovf <= 1'b0;

      irq_o <= irq_en & rx_valid;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state                        <= IDLE;
      spi_enable_o                 <= 1'b0;
      spi_write_data_o             <= '0;
      spi_write_data_bytes_valid_o <= BYTES_MAX;
    end else begin
      case (state)
        IDLE: begin
          if (~fifo_empty) begin
            {spi_write_data_bytes_valid_o, spi_write_data_o} <= fifo_rdata;
            spi_enable_o <= 1'b1;
            state        <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (spi_done_i) begin
            spi_enable_o <= 1'b0;
            state        <= GAP;
          end
        end
        GAP: state <= IDLE;
        default: begin
          spi_enable_o <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_spi_ctrl.sv
// Directed bench for ahb_spi_ctrl: bus reads and SPI frames are checked by
// monitors against expected queues filled by the stimulus.
module tb_ahb_spi_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel_i = 1'b0;
  logic [3:0]  haddr_i = '0;
  logic [1:0]  htrans_i = '0;
  logic        hwrite_i = 1'b0;
  logic        hready_i = 1'b1;
  logic [31:0] hwdata_i = '0;
  logic [31:0] hrdata_o;
  logic        hreadyout_o, hresp_o;
  logic        spi_enable_o;
  logic [31:0] spi_write_data_o;
  logic [2:0]  spi_write_data_bytes_valid_o;
  logic [31:0] spi_read_data_i = '0;
  logic [2:0]  spi_read_data_bytes_valid_i = '0;
  logic        spi_done_i = 1'b0;
  logic        irq_o;

  always #5 clk = ~clk;

  ahb_spi_ctrl #(.TX_DEPTH(4)) dut (
    .clk_i                        (clk),
    .rst_i                        (rst),
    .hsel_i                       (hsel_i),
    .haddr_i                      (haddr_i),
    .htrans_i                     (htrans_i),
    .hwrite_i                     (hwrite_i),
    .hready_i                     (hready_i),
    .hwdata_i                     (hwdata_i),
    .hrdata_o                     (hrdata_o),
    .hreadyout_o                  (hreadyout_o),
    .hresp_o                      (hresp_o),
    .spi_enable_o                 (spi_enable_o),
    .spi_write_data_o             (spi_write_data_o),
    .spi_write_data_bytes_valid_o (spi_write_data_bytes_valid_o),
    .spi_read_data_i              (spi_read_data_i),
    .spi_read_data_bytes_valid_i  (spi_read_data_bytes_valid_i),
    .spi_done_i                   (spi_done_i),
    .irq_o                        (irq_o)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [34:0] exp_frame_q[$];
  logic        rd_dp = 1'b0;

  logic        en_prev = 1'b0;
  logic        had_frame = 1'b0;
  logic [34:0] cur_frame = '0;
  logic [34:0] frame_now;
  int          low_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Read-data monitor
  always @(negedge clk) begin
    if (rd_dp) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_unexpected: got 0x%08h expected no read", hrdata_o);
      end else begin
        check(name_q.pop_front(), hrdata_o, exp_q.pop_front());
      end
    end
  end

  // SPI frame monitor: order, payload stability and inter-frame gap
  always @(negedge clk) begin
    frame_now = {spi_write_data_bytes_valid_o, spi_write_data_o};
    if (spi_enable_o && !en_prev) begin
      if (had_frame) begin
        checks++;
        if (low_cnt < 2) begin
          errors++;
          $display("FAIL frame_gap: got %0d low cycles expected >= 2", low_cnt);
        end
      end
      if (exp_frame_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_unexpected: got 0x%0h expected no frame", frame_now);
      end else begin
        check("frame", frame_now, exp_frame_q.pop_front());
      end
      cur_frame = frame_now;
      had_frame = 1'b1;
    end else if (spi_enable_o) begin
      check("frame_stable", frame_now, cur_frame);
    end
    if (!spi_enable_o) low_cnt++;
    else low_cnt = 0;
    en_prev = spi_enable_o;
  end

  task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data);
    hsel_i = 1'b1; htrans_i = 2'b10; hwrite_i = 1'b1; haddr_i = addr;
    @(posedge clk); #1;
    hsel_i = 1'b0; htrans_i = 2'b00; hwrite_i = 1'b0; hwdata_i = data;
    @(posedge clk); #1;
  endtask

  task automatic ahb_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
    hsel_i = 1'b1; htrans_i = 2'b10; hwrite_i = 1'b0; haddr_i = addr;
    @(posedge clk); #1;
    hsel_i = 1'b0; htrans_i = 2'b00;
    exp_q.push_back(exp);
    name_q.push_back(name);
    rd_dp = 1'b1;
    @(posedge clk); #1;
    rd_dp = 1'b0;
  endtask

  task automatic tx_frame(input logic [2:0] bytes, input logic [31:0] data);
    exp_frame_q.push_back({bytes, data});
    ahb_write(4'h0, data);
  endtask

  task automatic spi_done(input logic [31:0] rx, input logic [2:0] b);
    spi_read_data_i = rx;
    spi_read_data_bytes_valid_i = b;
    spi_done_i = 1'b1;
    @(posedge clk); #1;
    spi_done_i = 1'b0;
  endtask

  task automatic wait_enable(input string name);
    int n = 0;
    while (!spi_enable_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, spi_enable_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_hreadyout", hreadyout_o, 1'b1);
    check("rst_hresp", hresp_o, 1'b0);
    check("rst_enable", spi_enable_o, 1'b0);
    check("rst_wdata", spi_write_data_o, 32'h0);
    check("rst_wbytes", spi_write_data_bytes_valid_o, 3'd4);
    check("rst_irq", irq_o, 1'b0);
    check("rst_hrdata", hrdata_o, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    ahb_read(4'h4, 32'h0000_0004, "ctrl_reset");
    ahb_read(4'h8, 32'h0000_0004, "status_reset");

    // Single frame with BYTES=2 and latency from the data phase
    ahb_write(4'h4, 32'h0000_0002);
    tx_frame(3'd2, 32'h695A_0FC3);
    check("t1_en_before_pop", spi_enable_o, 1'b0);
    @(posedge clk); #1;
    check("t1_en_after_pop", spi_enable_o, 1'b1);
    check("t1_wdata", spi_write_data_o, 32'h695A_0FC3);
    check("t1_wbytes", spi_write_data_bytes_valid_o, 3'd2);
    spi_done(32'h0000_FFFF, 3'd2);
    check("t1_en_after_done", spi_enable_o, 1'b0);
    ahb_read(4'h8, 32'h0000_020C, "t1_status_rx");
    ahb_read(4'hC, 32'h0000_FFFF, "t1_rxdata");
    ahb_read(4'h8, 32'h0000_0204, "t1_status_after_read");
    ahb_read(4'h0, 32'h0000_0000, "t1_txdata_read");

    // FIFO overflow while a frame is active, then drain in order
    ahb_write(4'h4, 32'h0000_0003);
    tx_frame(3'd3, 32'h1111_0000);
    wait_enable("t2_first_enable");
    for (int k = 1; k <= 4; k++) tx_frame(3'd3, 32'h1111_0000 + k);
    ahb_write(4'h0, 32'h1111_0005);
    ahb_read(4'h8, 32'h0000_4223, "t2_status_full");
    for (int k = 0; k < 5; k++) begin
      wait_enable("t2_frame_enable");
      spi_done(32'hA000_0000 + k, 3'd3);
    end
    ahb_write(4'h8, 32'h0000_0030);
    ahb_read(4'h8, 32'h0000_030C, "t2_status_drained");
    ahb_read(4'hC, 32'hA000_0004, "t2_rxdata_last");

    // Two frames without a read: rx overflow, then W1C clear
    tx_frame(3'd3, 32'h2222_0001);
    wait_enable("t3_enable_a");
    spi_done(32'hB000_0001, 3'd1);
    tx_frame(3'd3, 32'h2222_0002);
    wait_enable("t3_enable_b");
    spi_done(32'hB000_0002, 3'd4);
    ahb_read(4'h8, 32'h0000_041C, "t3_status_ovf");
    ahb_read(4'hC, 32'hB000_0002, "t3_rxdata_second");
    ahb_write(4'h8, 32'h0000_0010);
    ahb_read(4'h8, 32'h0000_0404, "t3_status_cleared");

    // RXDATA read in the same cycle as a capture
    tx_frame(3'd3, 32'h3333_0001);
    wait_enable("t4_enable_a");
    spi_done(32'hC000_000A, 3'd2);
    tx_frame(3'd3, 32'h3333_0002);
    wait_enable("t4_enable_b");
    hsel_i = 1'b1; htrans_i = 2'b10; hwrite_i = 1'b0; haddr_i = 4'hC;
    @(posedge clk); #1;
    hsel_i = 1'b0; htrans_i = 2'b00;
    exp_q.push_back(32'hC000_000A);
    name_q.push_back("t4_rxdata_coincident");
    rd_dp = 1'b1;
    spi_read_data_i = 32'hC000_000B;
    spi_read_data_bytes_valid_i = 3'd1;
    spi_done_i = 1'b1;
    @(posedge clk); #1;
    rd_dp = 1'b0;
    spi_done_i = 1'b0;
    ahb_write(4'h8, 32'h0000_0030);
    ahb_read(4'h8, 32'h0000_010C, "t4_status_valid_kept");
    ahb_read(4'hC, 32'hC000_000B, "t4_rxdata_new");

    // BYTES normalisation and interrupt timing
    ahb_write(4'h4, 32'h0000_0000);
    ahb_read(4'h4, 32'h0000_0004, "t5_ctrl_bytes0");
    ahb_write(4'h4, 32'h0000_0100);
    ahb_read(4'h4, 32'h0000_0104, "t5_ctrl_irq_en");
    ahb_write(4'h4, 32'h0000_0107);
    ahb_read(4'h4, 32'h0000_0104, "t5_ctrl_bytes7");
    check("t5_irq_idle", irq_o, 1'b0);
    tx_frame(3'd4, 32'h4444_0001);
    wait_enable("t5_enable");
    spi_done(32'hD000_0001, 3'd4);
    check("t5_irq_same_cycle", irq_o, 1'b0);
    @(posedge clk); #1;
    check("t5_irq_rise", irq_o, 1'b1);

    // Asynchronous reset in the middle of a frame
    ahb_read(4'hC, 32'hD000_0001, "t6_rxdata_pre");
    tx_frame(3'd4, 32'h5555_0001);
    wait_enable("t6_enable");
    ahb_write(4'h0, 32'h5555_0002);
    #3;
    rst = 1'b1;
    #1;
    check("t6_async_enable_drop", spi_enable_o, 1'b0);
    check("t6_async_wbytes", spi_write_data_bytes_valid_o, 3'd4);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    ahb_read(4'h8, 32'h0000_0004, "t6_status_after_reset");
    ahb_read(4'h4, 32'h0000_0004, "t6_ctrl_after_reset");
    check("t6_irq_after_reset", irq_o, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("t6_no_frame_after_reset", spi_enable_o, 1'b0);

    check("read_queue_drained", exp_q.size(), 0);
    check("frame_queue_drained", exp_frame_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
